pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Parametrised hazard-control unit for the five-stage MIPS-style pipeline, generalised to DEPTH in-flight stages behind decode.
- Tracks every in-flight register writer in a shift register that advances in step with the pipeline registers.
- Generates operand-forwarding selects, load-use stalls with bubble insertion, branch flushes and a global freeze.
- Sits beside the decode stage; drives PC enable, IF/ID register enable/flush, and the ALU operand muxes.

Parameters:
DEPTH, 3, tracked stages after decode (index 0 = EX, 1 = MEM, 2 = WB)
REG_AW, 5, register-address width
LOAD_LAT, 1, stage index at which load data first becomes forwardable; loads in stages < LOAD_LAT force a stall
FW, $clog2(DEPTH+1), width of forwarding selects

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
id_valid  in  1  decode stage holds a real instruction
id_rs  in  REG_AW  source A address
id_rt  in  REG_AW  source B address
id_rs_used  in  1  source A is read
id_rt_used  in  1  source B is read
id_wr_en  in  1  decode instruction writes a register
id_wr_dst  in  REG_AW  its destination register
id_is_load  in  1  decode instruction is a load
ex_br_taken  in  1  branch in EX resolved taken
ext_stall  in  1  external freeze (e.g. memory busy)
pc_en  out  1  PC register load enable
ifid_en  out  1  IF/ID register enable
ifid_flush  out  1  clear IF/ID to a bubble
idex_bubble  out  1  ID/EX loads a bubble this cycle
fwd_a  out  FW  source A select: 0 = register file, k+1 = stage k result
fwd_b  out  FW  source B select, same encoding
stage_valid  out  DEPTH  valid bit per tracked stage

Behaviour:
- Entry state per stage k: {valid, wr_en, dst, is_load}. Async reset: all fields 0.
- All outputs are combinational from entry state and inputs.
  - During/after reset: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0, fwd_a=fwd_b=0, stage_valid=0.
- Match for operand X: entry k has valid & wr_en & dst != 0 & dst == X & X_used. Register 0 never matches.
- Forward select = k+1 of the youngest (lowest k) matching entry; 0 if no match.
- load_use: the youngest match of either operand has is_load=1 and k < LOAD_LAT, with id_valid=1.
- Priority, highest first:
  - ext_stall=1: pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=0. Entries hold. ex_br_taken is ignored this cycle; the branch entry stays in EX, so the flush occurs on the first unfrozen cycle.
  - ex_br_taken=1: pc_en=1, ifid_flush=1, idex_bubble=1. The decode instruction is discarded. Any load_use is ignored.
  - load_use=1: pc_en=0, ifid_en=0, idex_bubble=1.
  - Otherwise: pc_en=1, ifid_en=1, idex_bubble=0.
- Clock edge when ext_stall=0:
  - entry[k] <= entry[k-1] for k ≥ 1.
  - entry[0] <= (id_valid & !idex_bubble) ? {1, id_wr_en, id_wr_dst, id_is_load} : 0.
  - entry[DEPTH-1] retires.
- A load stall lasts exactly LOAD_LAT − k cycles, where k is the load's stage when first detected.
- Simultaneous matches in several stages: youngest wins (newest value).
- Reset asserted mid-stall/flush: all entries cleared immediately; no residual stall.

Optional Feature:
Macro HAZ_PERF_EN.
- Defined: adds outputs stall_cnt[31:0], flush_cnt[31:0] and freeze_cnt[31:0].
  - Each counts cycles with load_use stall, ex_br_taken flush, and ext_stall respectively, using the same priority as above (one counter per cycle at most).
  - Counters saturate at all-ones and reset to 0.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- Package pipe_hazard_pkg: hz_entry_t struct {valid, wr_en, dst, is_load}, constant FWD_RF = 0, function fwd width helper.
- Sub-module hazard_src_match: combinational priority search over DEPTH entries for one operand. Returns the select and an is_load flag. Instantiated twice (rs, rt).

Test Plan:
- Reset, then add $3,$1,$2 followed by sub $4,$3,$5 → on the sub in decode: fwd_a=1, no stall.
- lw $3 then add $4,$3,$3 (LOAD_LAT=1) → one cycle with pc_en=0, ifid_en=0, idex_bubble=1; next cycle fwd_a=fwd_b=2.
- Writes to $3 in stages 0 and 2, operand rs=$3 → fwd_a=1 (youngest); same with rs=$0 → fwd_a=0.
- Taken branch in EX while a load_use condition also holds → ifid_flush=1, pc_en=1, no stall; entry[0] is a bubble next cycle.
- ext_stall high for 3 cycles during a load_use → entries unchanged; stall resolves one cycle after ext_stall falls. With HAZ_PERF_EN: freeze_cnt=3, stall_cnt=1.
- rst pulsed asynchronously mid-stall → stage_valid=0 and pc_en=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_hazard_pkg.sv
// Shared types and helpers for the pipeline hazard-control unit.
// Optional feature macro: HAZ_PERF_EN (cycle counters on pipe_hazard_ctrl).
package pipe_hazard_pkg;

  // Destination field is stored at a fixed width; REG_AW must not exceed it.
  localparam int unsigned HZ_DST_W = 8;

  // Forwarding select value meaning "take the register file".
  localparam int unsigned FWD_RF = 0;

  // One in-flight register writer.
  typedef struct packed {
    logic                valid;
    logic                wr_en;
    logic [HZ_DST_W-1:0] dst;
    logic                is_load;
  } hz_entry_t;

  // Width needed to encode 0 (register file) plus DEPTH stage selects.
  function automatic int unsigned fwd_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Priority search for one source operand over the tracked stages.
// Youngest (lowest index) matching writer wins; register 0 never matches.
module hazard_src_match
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned FW     = fwd_width(DEPTH)
) (
  input  hz_entry_t [DEPTH-1:0] entries,
  input  logic [REG_AW-1:0]     src,
  input  logic                  src_used,
  output logic [FW-1:0]         sel,
  output logic                  is_load
);

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    sel     = FW'(FWD_RF);
    is_load = 1'b0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (entries[k].valid && entries[k].wr_en && src_used &&
          (src != '0) && (entries[k].dst == HZ_DST_W'(src))) begin
        sel     = FW'(k + 1);
        is_load = entries[k].is_load;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard-control unit beside decode: forwarding selects, load-use stalls,
// branch flushes and external freeze over DEPTH tracked stages.
// Optional feature macro: HAZ_PERF_EN adds stall/flush/freeze cycle counters.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned FW       = fwd_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_wr_dst,
  input  logic              id_is_load,
  input  logic              ex_br_taken,
  input  logic              ext_stall,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [FW-1:0]     fwd_a,
  output logic [FW-1:0]     fwd_b,
  output logic [DEPTH-1:0]  stage_valid
`ifdef HAZ_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt,
  output logic [31:0]       freeze_cnt
`endif
);

  hz_entry_t [DEPTH-1:0] entry_q;
  hz_entry_t [DEPTH-1:0] entry_d;
  hz_entry_t             new_entry;

  logic [FW-1:0] sel_a;
  logic [FW-1:0] sel_b;
  logic          ld_a;
  logic          ld_b;
  logic          load_use;

  hazard_src_match #(
    .DEPTH  (DEPTH),
    .REG_AW (REG_AW),
    .FW     (FW)
  ) u_match_rs (
    .entries  (entry_q),
    .src      (id_rs),
    .src_used (id_rs_used),
    .sel      (sel_a),
    .is_load  (ld_a)
  );

  hazard_src_match #(
    .DEPTH  (DEPTH),
    .REG_AW (REG_AW),
    .FW     (FW)
  ) u_match_rt (
    .entries  (entry_q),
    .src      (id_rt),
    .src_used (id_rt_used),
    .sel      (sel_b),
    .is_load  (ld_b)
  );

  // Load-use: youngest producer is a load still short of its forwarding stage
  // (select k+1 <= LOAD_LAT is the same as stage k < LOAD_LAT).
  always_comb begin
    load_use = 1'b0;
    if (id_valid) begin
      if (ld_a && (sel_a != FW'(FWD_RF)) && (32'(sel_a) <= LOAD_LAT)) begin
        load_use = 1'b1;
      end
      if (ld_b && (sel_b != FW'(FWD_RF)) && (32'(sel_b) <= LOAD_LAT)) begin
        load_use = 1'b1;
      end
    end
  end

  // Pipeline control with freeze > branch flush > load-use priority.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!rst) begin
      if (ext_stall) begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
      end else if (ex_br_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  // Operand selects and per-stage valid view.
  always_comb begin
    fwd_a = rst ? FW'(FWD_RF) : sel_a;
    fwd_b = rst ? FW'(FWD_RF) : sel_b;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      stage_valid[k] = entry_q[k].valid;
    end
  end

  // Entry shift: decode enters EX unless bubbled; frozen cycles hold.
  always_comb begin
    new_entry = '0;
    if (id_valid && !idex_bubble) begin
      new_entry.valid   = 1'b1;
      new_entry.wr_en   = id_wr_en;
      new_entry.dst     = HZ_DST_W'(id_wr_dst);
      new_entry.is_load = id_is_load;
    end
    entry_d = entry_q;
    if (!ext_stall) begin
      for (int unsigned k = 1; k < DEPTH; k++) begin
        entry_d[k] = entry_q[k-1];
      end
      entry_d[0] = new_entry;
    end
  end

  // Entry state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

`ifdef HAZ_PERF_EN
  logic [31:0] stall_cnt_q,  stall_cnt_d;
  logic [31:0] flush_cnt_q,  flush_cnt_d;
  logic [31:0] freeze_cnt_q, freeze_cnt_d;

  // At most one saturating counter advances per cycle, following control priority.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    freeze_cnt_d = freeze_cnt_q;
    if (ext_stall) begin
      if (freeze_cnt_q != '1) freeze_cnt_d = freeze_cnt_q + 32'd1;
    end else if (ex_br_taken) begin
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 32'd1;
    end else if (load_use) begin
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign freeze_cnt = freeze_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: driver pushes predicted outputs,
// monitor pops and compares on every falling edge.
module tb_pipe_hazard_ctrl;

  localparam int DEPTH    = 3;
  localparam int REG_AW   = 5;
  localparam int LOAD_LAT = 1;
  localparam int FW       = 2;

  logic clk, rst;
  logic id_valid, id_rs_used, id_rt_used, id_wr_en, id_is_load, ex_br_taken, ext_stall;
  logic [REG_AW-1:0] id_rs, id_rt, id_wr_dst;
  logic pc_en, ifid_en, ifid_flush, idex_bubble;
  logic [FW-1:0] fwd_a, fwd_b;
  logic [DEPTH-1:0] stage_valid;
`ifdef HAZ_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, freeze_cnt;
`endif

  pipe_hazard_ctrl #(.DEPTH(DEPTH), .REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT), .FW(FW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en),
    .id_wr_dst(id_wr_dst), .id_is_load(id_is_load), .ex_br_taken(ex_br_taken),
    .ext_stall(ext_stall), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b), .stage_valid(stage_valid)
`ifdef HAZ_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit rst, valid, rs_u, rt_u, wr, ld, br, xs;
    bit [4:0] rs, rt, dst;
  } stim_t;

  typedef struct {
    bit v, w, ld;
    bit [4:0] dst;
  } ment_t;

  typedef struct {
    bit pc_en, ifid_en, ifid_flush, idex_bubble;
    int fwd_a, fwd_b;
    bit [DEPTH-1:0] sv;
    int st, fl, fr;
  } exp_t;

  ment_t pipe[$];          // pipe[0] = EX, oldest at the back
  exp_t  exp_q[$];
  stim_t cur;
  exp_t  cur_exp;
  int    m_st, m_fl, m_fr;
  int    n_checks, n_err;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Youngest writer of r among in-flight instructions: stage index + 1, or 0.
  function automatic int find(input bit [4:0] r, input bit used);
    if (!used || r == 0) return 0;
    for (int k = 0; k < pipe.size(); k++)
      if (pipe[k].v && pipe[k].w && pipe[k].dst == r) return k + 1;
    return 0;
  endfunction

  function automatic bit load_use_of(input stim_t s);
    int fa, fb;
    bit hz;
    fa = find(s.rs, s.rs_u);
    fb = find(s.rt, s.rt_u);
    hz = 0;
    if (fa > 0 && pipe[fa-1].ld && (fa - 1) < LOAD_LAT) hz = 1;
    if (fb > 0 && pipe[fb-1].ld && (fb - 1) < LOAD_LAT) hz = 1;
    return s.valid && hz;
  endfunction

  function automatic exp_t predict(input stim_t s);
    exp_t e;
    e = '{pc_en: 1, ifid_en: 1, ifid_flush: 0, idex_bubble: 0, fwd_a: 0, fwd_b: 0,
          sv: '0, st: m_st, fl: m_fl, fr: m_fr};
    if (s.rst) begin
      e.st = 0; e.fl = 0; e.fr = 0;
      return e;
    end
    e.fwd_a = find(s.rs, s.rs_u);
    e.fwd_b = find(s.rt, s.rt_u);
    for (int k = 0; k < DEPTH; k++) e.sv[k] = pipe[k].v;
    if (s.xs) begin
      e.pc_en = 0; e.ifid_en = 0;
    end else if (s.br) begin
      e.ifid_flush = 1; e.idex_bubble = 1;
    end else if (load_use_of(s)) begin
      e.pc_en = 0; e.ifid_en = 0; e.idex_bubble = 1;
    end
    return e;
  endfunction

  // Model effect of the clock edge that ends the cycle described by cur.
  task automatic advance();
    ment_t n;
    if (cur.rst) begin
      foreach (pipe[k]) pipe[k] = '{v: 0, w: 0, ld: 0, dst: 0};
      m_st = 0; m_fl = 0; m_fr = 0;
      return;
    end
    if (cur.xs) m_fr++;
    else if (cur.br) m_fl++;
    else if (load_use_of(cur)) m_st++;
    if (!cur.xs) begin
      n = '{v: 0, w: 0, ld: 0, dst: 0};
      if (cur.valid && !cur_exp.idex_bubble) n = '{v: 1, w: cur.wr, ld: cur.ld, dst: cur.dst};
      pipe.push_front(n);
      void'(pipe.pop_back());
    end
  endtask

  task automatic apply(input stim_t s);
    rst = s.rst; id_valid = s.valid; id_rs = s.rs; id_rt = s.rt;
    id_rs_used = s.rs_u; id_rt_used = s.rt_u; id_wr_en = s.wr; id_wr_dst = s.dst;
    id_is_load = s.ld; ex_br_taken = s.br; ext_stall = s.xs;
  endtask

  task automatic cyc(input stim_t s);
    @(posedge clk);
    advance();
    #1;
    cur = s;
    apply(s);
    cur_exp = predict(s);
    exp_q.push_back(cur_exp);
  endtask

  function automatic stim_t nop();
    stim_t s;
    s = '{rst: 0, valid: 0, rs_u: 0, rt_u: 0, wr: 0, ld: 0, br: 0, xs: 0, rs: 0, rt: 0, dst: 0};
    return s;
  endfunction

  function automatic stim_t instr(input bit [4:0] dst, input bit [4:0] rs, input bit [4:0] rt,
                                  input bit ld);
    stim_t s;
    s = nop();
    s.valid = 1; s.wr = 1; s.dst = dst; s.ld = ld;
    s.rs = rs; s.rs_u = 1; s.rt = rt; s.rt_u = !ld;
    return s;
  endfunction

  task automatic drain();
    repeat (3) cyc(nop());
  endtask

  // Monitor: compare DUT against the oldest queued prediction.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb pc_en", 32'(pc_en), 32'(e.pc_en));
      chk("sb ifid_en", 32'(ifid_en), 32'(e.ifid_en));
      chk("sb ifid_flush", 32'(ifid_flush), 32'(e.ifid_flush));
      chk("sb idex_bubble", 32'(idex_bubble), 32'(e.idex_bubble));
      chk("sb fwd_a", 32'(fwd_a), 32'(e.fwd_a));
      chk("sb fwd_b", 32'(fwd_b), 32'(e.fwd_b));
      chk("sb stage_valid", 32'(stage_valid), 32'(e.sv));
`ifdef HAZ_PERF_EN
      chk("sb stall_cnt", stall_cnt, 32'(e.st));
      chk("sb flush_cnt", flush_cnt, 32'(e.fl));
      chk("sb freeze_cnt", freeze_cnt, 32'(e.fr));
`endif
    end
  end

  initial begin
    stim_t s;
`ifdef HAZ_PERF_EN
    int base_st, base_fr;
`endif
    n_checks = 0; n_err = 0;
    m_st = 0; m_fl = 0; m_fr = 0;
    repeat (DEPTH) pipe.push_back('{v: 0, w: 0, ld: 0, dst: 0});
    s = nop(); s.rst = 1;
    cur = s; apply(s); cur_exp = predict(s);
    cyc(s); cyc(s);
    @(negedge clk);
    chk("reset pc_en", 32'(pc_en), 1);
    chk("reset stage_valid", 32'(stage_valid), 0);
    drain();

    // Forward ALU result from EX.
    cyc(instr(3, 1, 2, 0));
    cyc(instr(4, 3, 5, 0));
    @(negedge clk);
    chk("A fwd_a", 32'(fwd_a), 1);
    chk("A pc_en", 32'(pc_en), 1);
    drain();

    // Load-use: one stall cycle, then forward from MEM.
    cyc(instr(3, 1, 0, 1));
    cyc(instr(4, 3, 3, 0));
    @(negedge clk);
    chk("B stall pc_en", 32'(pc_en), 0);
    chk("B stall ifid_en", 32'(ifid_en), 0);
    chk("B stall bubble", 32'(idex_bubble), 1);
    cyc(instr(4, 3, 3, 0));
    @(negedge clk);
    chk("B fwd_a", 32'(fwd_a), 2);
    chk("B fwd_b", 32'(fwd_b), 2);
    chk("B pc_en", 32'(pc_en), 1);
    drain();

    // Youngest writer wins; $0 never forwards.
    cyc(instr(3, 1, 2, 0));
    cyc(instr(0, 1, 2, 0));
    cyc(instr(3, 1, 2, 0));
    s = instr(7, 3, 0, 0);
    cyc(s);
    @(negedge clk);
    chk("C fwd_a youngest", 32'(fwd_a), 1);
    chk("C fwd_b r0", 32'(fwd_b), 0);
    drain();

    // Taken branch overrides load-use.
    cyc(instr(3, 1, 0, 1));
    s = instr(4, 3, 3, 0); s.br = 1;
    cyc(s);
    @(negedge clk);
    chk("D ifid_flush", 32'(ifid_flush), 1);
    chk("D pc_en", 32'(pc_en), 1);
    chk("D bubble", 32'(idex_bubble), 1);
    cyc(nop());
    @(negedge clk);
    chk("D EX bubble", 32'(stage_valid[0]), 0);
    drain();

    // Freeze during load-use holds entries; stall resolves after release.
    cyc(instr(3, 1, 0, 1));
`ifdef HAZ_PERF_EN
    base_st = int'(stall_cnt); base_fr = int'(freeze_cnt);
`endif
    s = instr(4, 3, 6, 0); s.xs = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(s);
      @(negedge clk);
      chk("E frozen pc_en", 32'(pc_en), 0);
      chk("E frozen bubble", 32'(idex_bubble), 0);
      chk("E frozen stage_valid", 32'(stage_valid), 1);
    end
    s.xs = 0;
    cyc(s);
    @(negedge clk);
    chk("E stall after freeze", 32'(idex_bubble), 1);
    cyc(s);
    @(negedge clk);
    chk("E resolved pc_en", 32'(pc_en), 1);
    chk("E resolved fwd_a", 32'(fwd_a), 2);
`ifdef HAZ_PERF_EN
    chk("E freeze_cnt delta", freeze_cnt - 32'(base_fr), 3);
    chk("E stall_cnt delta", stall_cnt - 32'(base_st), 1);
`endif
    drain();

    // Asynchronous reset in the middle of a load-use stall.
    cyc(instr(3, 1, 0, 1));
    cyc(instr(4, 3, 3, 0));
    #1;
    chk("F pre-reset pc_en", 32'(pc_en), 0);
    #1;
    rst = 1'b1;
    cur.rst = 1;
    cur_exp = predict(cur);
    exp_q[exp_q.size() - 1] = cur_exp;
    #1;
    chk("F async pc_en", 32'(pc_en), 1);
    chk("F async stage_valid", 32'(stage_valid), 0);
    chk("F async bubble", 32'(idex_bubble), 0);
    cyc(nop());
    drain();

    // Randomised traffic over a small register set to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      s = nop();
      s.rst   = ($urandom_range(0, 63) == 0);
      s.valid = ($urandom_range(0, 7) != 0);
      s.rs    = 5'($urandom_range(0, 3));
      s.rt    = 5'($urandom_range(0, 3));
      s.rs_u  = ($urandom_range(0, 3) != 0);
      s.rt_u  = ($urandom_range(0, 3) != 0);
      s.wr    = ($urandom_range(0, 3) != 0);
      s.dst   = 5'($urandom_range(0, 3));
      s.ld    = ($urandom_range(0, 2) == 0);
      s.br    = ($urandom_range(0, 9) == 0);
      s.xs    = ($urandom_range(0, 6) == 0);
      cyc(s);
    end
    cyc(nop());
    @(negedge clk);
    #1;
    chk("scoreboard drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
